exu_gpr_wb_arb: RTL and testbench

Write-back arbiter for the EXU's single GPR write port. Each cycle it grants the port to one of two requesters: the single-cycle instruction handlers (exec port), or load data returned by the LSU. Load returns are buffered in a small FIFO, so the LSU never has to match the exec pipeline's timing. It also reports whether a given register has a pending load write, which the issue logic uses for RAW stalls.

---
 rtl/exu_gpr_wb_arb_if.sv | 42 ++++
 rtl/exu_gpr_wb_arb.sv | 150 +++++++++++++++
 tb/tb_exu_gpr_wb_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_gpr_wb_arb_if.sv
// Bundle of the write-back arbiter's request, response and query signals.
// The arbiter connects through the slave modport; the exec handlers, the LSU,
// the GPR file and the issue logic together make up the master side.
interface exu_gpr_wb_arb_if;
    logic        ex_wb_vld;
    logic        ex_wb_rdy;
    logic [4:0]  ex_wb_addr;
    logic [31:0] ex_wb_data;

    logic        ld_wb_vld;
    logic        ld_wb_rdy;
    logic [4:0]  ld_wb_addr;
    logic [31:0] ld_wb_data;

    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;

    logic [4:0]  chk_addr;
    logic        chk_hit;
    logic        ld_pend;

    modport master (
        output ex_wb_vld, ex_wb_addr, ex_wb_data,
        input  ex_wb_rdy,
        output ld_wb_vld, ld_wb_addr, ld_wb_data,
        input  ld_wb_rdy,
        input  gpr_wen, gpr_waddr, gpr_wdata,
        output chk_addr,
        input  chk_hit, ld_pend
    );

    modport slave (
        input  ex_wb_vld, ex_wb_addr, ex_wb_data,
        output ex_wb_rdy,
        input  ld_wb_vld, ld_wb_addr, ld_wb_data,
        output ld_wb_rdy,
        output gpr_wen, gpr_waddr, gpr_wdata,
        input  chk_addr,
        output chk_hit, ld_pend
    );
endinterface

// File: rtl/exu_gpr_wb_arb.sv
// Write-back arbiter for the EXU's single GPR write port.
// Exec results go straight through with zero latency; LSU load returns are
// buffered in a small FIFO and written when exec is idle, when the FIFO is
// full, or (with EXU_WB_STARVE_GUARD_EN defined) when the head has been
// denied MAX_WAIT times. Without EXU_WB_STARVE_GUARD_EN there is no wait
// counter and MAX_WAIT only takes part in the parameter legality check.
// Also reports whether a register has a pending load write (RAW stalls).
module exu_gpr_wb_arb #(
    parameter int LD_FIFO_DEPTH = 2,
    parameter int MAX_WAIT      = 4
) (
    input  logic            clk,
    input  logic            rst,
    exu_gpr_wb_arb_if.slave wb
);
    localparam int AW = $clog2(LD_FIFO_DEPTH);
    localparam int PW = AW + 1;

    // Reject parameter values the pointer arithmetic cannot handle
    if (LD_FIFO_DEPTH < 2 || (LD_FIFO_DEPTH & (LD_FIFO_DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_paramCheck
        $error("exu_gpr_wb_arb: LD_FIFO_DEPTH must be a power of two >= 2 and MAX_WAIT >= 1");
    end

    logic [4:0]              entAddr_q [LD_FIFO_DEPTH];
    logic [31:0]             entData_q [LD_FIFO_DEPTH];
    logic [PW-1:0]           wrPtr_q, wrPtr_d;
    logic [PW-1:0]           rdPtr_q, rdPtr_d;
    logic [PW-1:0]           count;
    logic [AW-1:0]           headIdx;
    logic [AW-1:0]           tailIdx;
    logic [LD_FIFO_DEPTH-1:0] entValid;
    logic                    empty;
    logic                    full;
    logic                    starve;
    logic                    grantLd;
    logic                    ldHsk;
    logic                    push;
    logic                    pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign count   = wrPtr_q - rdPtr_q;
    assign empty   = (count == '0);
    assign full    = (count == PW'(LD_FIFO_DEPTH));
    assign headIdx = rdPtr_q[AW-1:0];
    assign tailIdx = wrPtr_q[AW-1:0];

    // Ready looks only at registered occupancy, never at a same-cycle pop
    assign wb.ld_wb_rdy = !full;
    assign ldHsk        = wb.ld_wb_vld && !full;
    assign push         = ldHsk && (wb.ld_wb_addr != 5'd0);
    assign pop          = grantLd;

    // A buffered load wins when exec is idle, the FIFO is full, or it starved
    assign grantLd      = !empty && (!wb.ex_wb_vld || full || starve);
    assign wb.ex_wb_rdy = !grantLd;
    assign wb.ld_pend   = !empty;

`ifdef EXU_WB_STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] MAX_WAIT_C = WW'(MAX_WAIT);

    logic [WW-1:0] waitCnt_q, waitCnt_d;

    // Count cycles a waiting head is denied, saturating at the starve limit
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (pop || empty) begin
            waitCnt_d = '0;
        end else if (!starve) begin
            waitCnt_d = waitCnt_q + WW'(1);
        end
    end

    // Wait counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
        end
    end

    assign starve = (waitCnt_q == MAX_WAIT_C);
`else
    assign starve = 1'b0;
`endif

    // Advance tail on a real push and head on a pop; wrap is natural modulo
    always_comb begin
        wrPtr_d = wrPtr_q + {{AW{1'b0}}, push};
        rdPtr_d = rdPtr_q + {{AW{1'b0}}, pop};
    end

    // Pointer registers; reset drops every buffered load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Entry storage needs no reset: validity comes only from the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            entAddr_q[tailIdx] <= wb.ld_wb_addr;
            entData_q[tailIdx] <= wb.ld_wb_data;
        end
    end

    // An entry is live when its distance from the head is below occupancy
    for (genvar i = 0; i < LD_FIFO_DEPTH; i++) begin : g_ent
        logic [AW-1:0] offs;
        assign offs        = AW'(i) - headIdx;
        assign entValid[i] = ({1'b0, offs} < count);
    end

    // Pending-load query covers live entries and a push accepted this cycle
    always_comb begin
        wb.chk_hit = 1'b0;
        if (wb.chk_addr != 5'd0) begin
            for (int i = 0; i < LD_FIFO_DEPTH; i++) begin
                if (entValid[i] && (entAddr_q[i] == wb.chk_addr)) begin
                    wb.chk_hit = 1'b1;
                end
            end
            if (push && (wb.ld_wb_addr == wb.chk_addr)) begin
                wb.chk_hit = 1'b1;
            end
        end
    end

    // Drive the GPR write port from the FIFO head or from the exec request
    always_comb begin
        wb.gpr_wen   = 1'b0;
        wb.gpr_waddr = 5'd0;
        wb.gpr_wdata = 32'd0;
        if (grantLd) begin
            wb.gpr_wen   = 1'b1;
            wb.gpr_waddr = entAddr_q[headIdx];
            wb.gpr_wdata = entData_q[headIdx];
        end else if (wb.ex_wb_vld) begin
            wb.gpr_wen   = (wb.ex_wb_addr != 5'd0);
            wb.gpr_waddr = wb.ex_wb_addr;
            wb.gpr_wdata = wb.ex_wb_data;
        end
    end
endmodule

// File: tb/tb_exu_gpr_wb_arb.sv
// Self-checking bench for exu_gpr_wb_arb: directed scenarios plus a random
// run, all compared against a queue-based reference model of the arbiter.
module tb_exu_gpr_wb_arb;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
`ifdef EXU_WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exu_gpr_wb_arb_if wb();

    exu_gpr_wb_arb #(
        .LD_FIFO_DEPTH(DEPTH),
        .MAX_WAIT     (MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb (wb)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pending loads as {addr,data} in arrival order
    logic [36:0] mq[$];
    int          mWait;
    bit          mGLd, mExHsk, mLdHsk;
    bit          expExRdy, expLdRdy, expWen, expHit, expPend;
    logic [4:0]  expWaddr;
    logic [31:0] expWdata;

    task automatic model_reset();
        mq.delete();
        mWait = 0;
    endtask

    // Predict this cycle's outputs from model state and the current inputs
    task automatic model_eval();
        bit          mFull, mEmpty, mStarve;
        logic [36:0] h;
        mFull    = (mq.size() == DEPTH);
        mEmpty   = (mq.size() == 0);
        mStarve  = GUARD && (mWait >= MAX_WAIT);
        mGLd     = !mEmpty && (!wb.ex_wb_vld || mFull || mStarve);
        mExHsk   = wb.ex_wb_vld && !mGLd;
        mLdHsk   = wb.ld_wb_vld && !mFull;
        expExRdy = !mGLd;
        expLdRdy = !mFull;
        expPend  = !mEmpty;
        expWen   = 1'b0;
        expWaddr = 5'd0;
        expWdata = 32'd0;
        if (mGLd) begin
            h        = mq[0];
            expWen   = 1'b1;
            expWaddr = h[36:32];
            expWdata = h[31:0];
        end else if (wb.ex_wb_vld) begin
            expWen   = (wb.ex_wb_addr != 5'd0);
            expWaddr = wb.ex_wb_addr;
            expWdata = wb.ex_wb_data;
        end
        expHit = 1'b0;
        if (wb.chk_addr != 5'd0) begin
            foreach (mq[i]) if (mq[i][36:32] == wb.chk_addr) expHit = 1'b1;
            if (mLdHsk && wb.ld_wb_addr == wb.chk_addr) expHit = 1'b1;
        end
    endtask

    // Apply the clock edge to the model using the values seen at eval time
    task automatic model_tick();
        if (mGLd || mq.size() == 0) mWait = 0;
        else if (mWait < MAX_WAIT) mWait++;
        if (mGLd) void'(mq.pop_front());
        if (mLdHsk && wb.ld_wb_addr != 5'd0) mq.push_back({wb.ld_wb_addr, wb.ld_wb_data});
    endtask

    task automatic drive_idle();
        wb.ex_wb_vld  = 1'b0;
        wb.ex_wb_addr = 5'd0;
        wb.ex_wb_data = 32'd0;
        wb.ld_wb_vld  = 1'b0;
        wb.ld_wb_addr = 5'd0;
        wb.ld_wb_data = 32'd0;
        wb.chk_addr   = 5'd0;
    endtask

    task automatic edge_tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    // Outputs while reset is held, then the idle state after release
    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        model_reset();
        @(negedge clk);
        checks++; if (wb.ld_wb_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rst_ld_rdy: got %b want 1", wb.ld_wb_rdy); end
        checks++; if (wb.ex_wb_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rst_ex_rdy: got %b want 1", wb.ex_wb_rdy); end
        checks++; if (wb.gpr_wen !== 1'b0) begin errors++; $display("[TB] FAIL rst_wen: got %b want 0", wb.gpr_wen); end
        checks++; if (wb.gpr_waddr !== 5'd0) begin errors++; $display("[TB] FAIL rst_waddr: got %0d want 0", wb.gpr_waddr); end
        checks++; if (wb.gpr_wdata !== 32'd0) begin errors++; $display("[TB] FAIL rst_wdata: got %0h want 0", wb.gpr_wdata); end
        checks++; if (wb.chk_hit !== 1'b0) begin errors++; $display("[TB] FAIL rst_chk_hit: got %b want 0", wb.chk_hit); end
        checks++; if (wb.ld_pend !== 1'b0) begin errors++; $display("[TB] FAIL rst_ld_pend: got %b want 0", wb.ld_pend); end
        rst = 1'b0;
        model_eval();
        edge_tick();
        @(negedge clk);
        model_eval();
        checks++; if (wb.ld_wb_rdy !== 1'b1 || wb.ex_wb_rdy !== 1'b1) begin errors++; $display("[TB] FAIL idle_rdy: got ld=%b ex=%b want 1/1", wb.ld_wb_rdy, wb.ex_wb_rdy); end
        checks++; if (wb.gpr_wen !== 1'b0 || wb.ld_pend !== 1'b0) begin errors++; $display("[TB] FAIL idle_wen_pend: got wen=%b pend=%b want 0/0", wb.gpr_wen, wb.ld_pend); end
        edge_tick();
    endtask

    // Exec write x5=0x1234 appears on the port in the same cycle
    task automatic test_exec_write();
        wb.ex_wb_vld  = 1'b1;
        wb.ex_wb_addr = 5'd5;
        wb.ex_wb_data = 32'h1234;
        @(negedge clk);
        model_eval();
        checks++; if (wb.ex_wb_rdy !== 1'b1) begin errors++; $display("[TB] FAIL exec_rdy: got %b want 1", wb.ex_wb_rdy); end
        checks++; if (wb.gpr_wen !== 1'b1 || wb.gpr_waddr !== 5'd5 || wb.gpr_wdata !== 32'h1234) begin
            errors++; $display("[TB] FAIL exec_write: got wen=%b a=%0d d=%0h want 1/5/1234", wb.gpr_wen, wb.gpr_waddr, wb.gpr_wdata);
        end
        edge_tick();
        drive_idle();
    endtask

    // Load x7=0xDEAD with exec idle is written one cycle after its handshake
    task automatic test_load_write();
        wb.ld_wb_vld  = 1'b1;
        wb.ld_wb_addr = 5'd7;
        wb.ld_wb_data = 32'hDEAD;
        wb.chk_addr   = 5'd7;
        @(negedge clk);
        model_eval();
        checks++; if (wb.chk_hit !== 1'b1) begin errors++; $display("[TB] FAIL load_hit_hsk: got %b want 1", wb.chk_hit); end
        checks++; if (wb.ld_wb_rdy !== 1'b1 || wb.gpr_wen !== 1'b0) begin errors++; $display("[TB] FAIL load_hsk: got rdy=%b wen=%b want 1/0", wb.ld_wb_rdy, wb.gpr_wen); end
        edge_tick();
        wb.ld_wb_vld = 1'b0;
        @(negedge clk);
        model_eval();
        checks++; if (wb.gpr_wen !== 1'b1 || wb.gpr_waddr !== 5'd7 || wb.gpr_wdata !== 32'hDEAD) begin
            errors++; $display("[TB] FAIL load_write: got wen=%b a=%0d d=%0h want 1/7/dead", wb.gpr_wen, wb.gpr_waddr, wb.gpr_wdata);
        end
        checks++; if (wb.chk_hit !== 1'b1 || wb.ld_pend !== 1'b1) begin errors++; $display("[TB] FAIL load_pend: got hit=%b pend=%b want 1/1", wb.chk_hit, wb.ld_pend); end
        edge_tick();
        @(negedge clk);
        model_eval();
        checks++; if (wb.ld_pend !== 1'b0 || wb.chk_hit !== 1'b0) begin errors++; $display("[TB] FAIL load_drained: got pend=%b hit=%b want 0/0", wb.ld_pend, wb.chk_hit); end
        edge_tick();
        drive_idle();
    endtask

    // Writes to x0 from both sides handshake but never reach the GPR file
    task automatic test_x0();
        wb.ex_wb_vld  = 1'b1;
        wb.ex_wb_addr = 5'd0;
        wb.ex_wb_data = 32'h55;
        wb.ld_wb_vld  = 1'b1;
        wb.ld_wb_addr = 5'd0;
        wb.ld_wb_data = 32'h66;
        wb.chk_addr   = 5'd0;
        @(negedge clk);
        model_eval();
        checks++; if (wb.ex_wb_rdy !== 1'b1 || wb.ld_wb_rdy !== 1'b1) begin errors++; $display("[TB] FAIL x0_rdy: got ex=%b ld=%b want 1/1", wb.ex_wb_rdy, wb.ld_wb_rdy); end
        checks++; if (wb.gpr_wen !== 1'b0 || wb.chk_hit !== 1'b0) begin errors++; $display("[TB] FAIL x0_wen_hit: got wen=%b hit=%b want 0/0", wb.gpr_wen, wb.chk_hit); end
        edge_tick();
        drive_idle();
        @(negedge clk);
        model_eval();
        checks++; if (wb.ld_pend !== 1'b0 || wb.gpr_wen !== 1'b0) begin errors++; $display("[TB] FAIL x0_no_entry: got pend=%b wen=%b want 0/0", wb.ld_pend, wb.gpr_wen); end
        edge_tick();
    endtask

    // One load x3 buffered under streaming exec; find the cycle it is written
    task automatic test_starvation();
        int seen;
        seen = -1;
        wb.ex_wb_vld  = 1'b1;
        wb.ex_wb_addr = 5'd10;
        wb.ex_wb_data = 32'h100;
        wb.ld_wb_vld  = 1'b1;
        wb.ld_wb_addr = 5'd3;
        wb.ld_wb_data = 32'h3333;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            model_eval();
            checks++;
            if (wb.gpr_wen !== expWen || wb.gpr_waddr !== expWaddr || wb.ex_wb_rdy !== expExRdy) begin
                errors++; $display("[TB] FAIL starve_cycle%0d: got wen=%b a=%0d exrdy=%b want %b/%0d/%b", k, wb.gpr_wen, wb.gpr_waddr, wb.ex_wb_rdy, expWen, expWaddr, expExRdy);
            end
            if (seen < 0 && wb.gpr_wen === 1'b1 && wb.gpr_waddr === 5'd3) seen = k;
            edge_tick();
            if (mLdHsk) wb.ld_wb_vld = 1'b0;
            if (mExHsk) begin
                if (k >= 8) wb.ex_wb_vld = 1'b0;
                wb.ex_wb_addr = wb.ex_wb_addr + 5'd1;
                wb.ex_wb_data = wb.ex_wb_data + 32'd1;
            end
        end
        checks++; if (seen !== (GUARD ? 5 : 9)) begin errors++; $display("[TB] FAIL starve_latency: got cycle %0d want %0d", seen, GUARD ? 5 : 9); end
        drive_idle();
    endtask

    // Three loads against busy exec: fill, forced drain, refill across wrap
    task automatic test_full();
        logic [4:0]  ldAddr [3];
        logic [4:0]  got[$];
        int          ldIdx;
        ldAddr[0] = 5'd11; ldAddr[1] = 5'd12; ldAddr[2] = 5'd13;
        ldIdx = 0;
        wb.ex_wb_vld  = 1'b1;
        wb.ex_wb_addr = 5'd20;
        wb.ex_wb_data = 32'h200;
        wb.ld_wb_vld  = 1'b1;
        wb.ld_wb_addr = ldAddr[0];
        wb.ld_wb_data = 32'hA000;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            model_eval();
            checks++;
            if (wb.gpr_wen !== expWen || wb.gpr_waddr !== expWaddr || wb.gpr_wdata !== expWdata ||
                wb.ex_wb_rdy !== expExRdy || wb.ld_wb_rdy !== expLdRdy) begin
                errors++; $display("[TB] FAIL full_cycle%0d: got wen=%b a=%0d ex=%b ld=%b want %b/%0d/%b/%b", k, wb.gpr_wen, wb.gpr_waddr, wb.ex_wb_rdy, wb.ld_wb_rdy, expWen, expWaddr, expExRdy, expLdRdy);
            end
            if (k == 2) begin
                checks++; if (wb.ld_wb_rdy !== 1'b0 || wb.ex_wb_rdy !== 1'b0) begin errors++; $display("[TB] FAIL full_stall: got ld=%b ex=%b want 0/0", wb.ld_wb_rdy, wb.ex_wb_rdy); end
            end
            if (wb.gpr_wen === 1'b1 && wb.gpr_waddr >= 5'd11 && wb.gpr_waddr <= 5'd13) got.push_back(wb.gpr_waddr);
            edge_tick();
            if (mLdHsk) begin
                ldIdx++;
                if (ldIdx < 3) begin
                    wb.ld_wb_addr = ldAddr[ldIdx];
                    wb.ld_wb_data = 32'hA000 + 32'(ldIdx);
                end else begin
                    wb.ld_wb_vld = 1'b0;
                end
            end
            if (mExHsk) begin
                if (k >= 6) wb.ex_wb_vld = 1'b0;
                wb.ex_wb_addr = wb.ex_wb_addr + 5'd1;
            end
        end
        checks++;
        if (got.size() != 3 || got[0] !== 5'd11 || got[1] !== 5'd12 || got[2] !== 5'd13) begin
            errors++; $display("[TB] FAIL full_order: got %0d writes first=%0d want 3 writes 11,12,13", got.size(), (got.size() > 0) ? got[0] : 5'd0);
        end
        drive_idle();
    endtask

    // Async reset with two loads pending clears state and leaves no stale write
    task automatic test_reset_mid();
        wb.ex_wb_vld  = 1'b1;
        wb.ex_wb_addr = 5'd25;
        wb.ex_wb_data = 32'h250;
        wb.ld_wb_vld  = 1'b1;
        wb.ld_wb_addr = 5'd14;
        wb.ld_wb_data = 32'hE000;
        @(negedge clk);
        model_eval();
        edge_tick();
        wb.ld_wb_addr = 5'd15;
        @(negedge clk);
        model_eval();
        edge_tick();
        drive_idle();
        checks++; if (wb.ld_pend !== 1'b1 || wb.ld_wb_rdy !== 1'b0) begin errors++; $display("[TB] FAIL mid_prefill: got pend=%b ldrdy=%b want 1/0", wb.ld_pend, wb.ld_wb_rdy); end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (wb.ld_pend !== 1'b0 || wb.ld_wb_rdy !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst: got pend=%b ldrdy=%b want 0/1", wb.ld_pend, wb.ld_wb_rdy); end
        checks++; if (wb.gpr_wen !== 1'b0 || wb.ex_wb_rdy !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_port: got wen=%b exrdy=%b want 0/1", wb.gpr_wen, wb.ex_wb_rdy); end
        @(negedge clk);
        rst = 1'b0;
        model_eval();
        edge_tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            model_eval();
            checks++; if (wb.gpr_wen !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale%0d: got wen=%b want 0", k, wb.gpr_wen); end
            edge_tick();
        end
    endtask

    // Random traffic obeying the hold-until-handshake rules, fully compared
    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            wb.chk_addr = 5'($urandom_range(0, 7));
            @(negedge clk);
            model_eval();
            checks++; if (wb.ex_wb_rdy !== expExRdy) begin errors++; $display("[TB] FAIL rnd%0d_ex_rdy: got %b want %b", k, wb.ex_wb_rdy, expExRdy); end
            checks++; if (wb.ld_wb_rdy !== expLdRdy) begin errors++; $display("[TB] FAIL rnd%0d_ld_rdy: got %b want %b", k, wb.ld_wb_rdy, expLdRdy); end
            checks++; if (wb.gpr_wen !== expWen) begin errors++; $display("[TB] FAIL rnd%0d_wen: got %b want %b", k, wb.gpr_wen, expWen); end
            checks++; if (wb.gpr_waddr !== expWaddr) begin errors++; $display("[TB] FAIL rnd%0d_waddr: got %0d want %0d", k, wb.gpr_waddr, expWaddr); end
            checks++; if (wb.gpr_wdata !== expWdata) begin errors++; $display("[TB] FAIL rnd%0d_wdata: got %0h want %0h", k, wb.gpr_wdata, expWdata); end
            checks++; if (wb.chk_hit !== expHit) begin errors++; $display("[TB] FAIL rnd%0d_chk_hit: got %b want %b", k, wb.chk_hit, expHit); end
            checks++; if (wb.ld_pend !== expPend) begin errors++; $display("[TB] FAIL rnd%0d_ld_pend: got %b want %b", k, wb.ld_pend, expPend); end
            edge_tick();
            if (!wb.ex_wb_vld || mExHsk) begin
                wb.ex_wb_vld  = ($urandom_range(0, 99) < 65);
                wb.ex_wb_addr = 5'($urandom_range(0, 7));
                wb.ex_wb_data = $urandom;
            end
            if (!wb.ld_wb_vld || mLdHsk) begin
                wb.ld_wb_vld  = ($urandom_range(0, 99) < 45);
                wb.ld_wb_addr = 5'($urandom_range(0, 7));
                wb.ld_wb_data = $urandom;
            end
        end
        drive_idle();
    endtask

    // Run every scenario in order, then report
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_exec_write();
        test_load_write();
        test_x0();
        test_starvation();
        test_full();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end
endmodule
